// File: rtl/arm_mem_responder.sv
// 256-byte word/byte memory slave answering an MFA/MFC handshake after WAIT_CYCLES wait states.
// Optional ARM_MEM_ALIGN_CHECK_EN adds a MISALIGN flag and blocks misaligned word accesses.
module arm_mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MFA,
    input  logic [7:0]  MEMADD,
    input  logic        READ_WRITE,
    input  logic        WORD_BYTE,
    input  logic [31:0] DATAIN,
    output logic [31:0] MEMDAT,
`ifdef ARM_MEM_ALIGN_CHECK_EN
    output logic        MISALIGN,
`endif
    output logic        MFC
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DAT_W  = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORDS  = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                mfc_nxt;
    logic [DAT_W-1:0]    memdat_nxt;

    logic [ADDR_W-1:0]   lat_addr;
    logic                lat_rw;
    logic                lat_wb;
    logic [DAT_W-1:0]    lat_din;

    logic [DAT_W-1:0]    mem [WORDS];

    logic                accept_c;
    logic                mem_we_c;
    logic                bad_align_c;
    logic [5:0]          idx_c;
    logic [1:0]          lane_c;
    logic [DAT_W-1:0]    rword_c;
    logic [DAT_W-1:0]    wword_c;
    logic [DAT_W-1:0]    rdata_c;

`ifdef ARM_MEM_ALIGN_CHECK_EN
    logic                misalign_nxt;
`endif

    assign idx_c  = lat_addr[7:2];
    assign lane_c = lat_addr[1:0];

    // Lane-merged write word and zero-extended read data for the latched request
    always_comb begin
        rword_c = mem[idx_c];
        wword_c = rword_c;
        if (lat_wb) begin
            wword_c = lat_din;
        end else begin
            wword_c[{lane_c, 3'b000} +: 8] = lat_din[7:0];
        end
        rdata_c = lat_wb ? rword_c : {24'h0, rword_c[{lane_c, 3'b000} +: 8]};
    end

`ifdef ARM_MEM_ALIGN_CHECK_EN
    assign bad_align_c = lat_wb && (lane_c != 2'b00);
`else
    assign bad_align_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mfc_nxt    = MFC;
        memdat_nxt = MEMDAT;
        accept_c   = 1'b0;
        mem_we_c   = 1'b0;
`ifdef ARM_MEM_ALIGN_CHECK_EN
        misalign_nxt = MISALIGN;
`endif
        case (state)
            IDLE: begin
                if (MFA) begin
                    accept_c  = 1'b1;
                    cnt_nxt   = CNT_W'(WAIT_CYCLES);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!MFA) begin
                    // Requester withdrew: abandon without touching storage
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = DONE;
                    mfc_nxt   = 1'b1;
                    mem_we_c  = !lat_rw && !bad_align_c;
                    if (bad_align_c) begin
                        memdat_nxt = '0;
                    end else if (lat_rw) begin
                        memdat_nxt = rdata_c;
                    end
`ifdef ARM_MEM_ALIGN_CHECK_EN
                    misalign_nxt = bad_align_c;
`endif
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_nxt = IDLE;
                    mfc_nxt   = 1'b0;
`ifdef ARM_MEM_ALIGN_CHECK_EN
                    misalign_nxt = 1'b0;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            MFC    <= 1'b0;
            MEMDAT <= '0;
`ifdef ARM_MEM_ALIGN_CHECK_EN
            MISALIGN <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            MFC    <= mfc_nxt;
            MEMDAT <= memdat_nxt;
`ifdef ARM_MEM_ALIGN_CHECK_EN
            MISALIGN <= misalign_nxt;
`endif
        end
    end

    // Request capture; later input changes are ignored until the next acceptance
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lat_addr <= '0;
            lat_rw   <= 1'b0;
            lat_wb   <= 1'b0;
            lat_din  <= '0;
        end else if (accept_c) begin
            lat_addr <= MEMADD;
            lat_rw   <= READ_WRITE;
            lat_wb   <= WORD_BYTE;
            lat_din  <= DATAIN;
        end
    end

    // Storage survives reset; reset only blocks a write landing in the same cycle
    always_ff @(posedge Clk) begin
        if (!Reset && mem_we_c) begin
            mem[idx_c] <= wword_c;
        end
    end

endmodule

// File: tb/tb_arm_mem_responder.sv
// Directed bench for arm_mem_responder: one instance with 2 wait states, one with none.
module tb_arm_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mfa_a, rw_a, wb_a, mfc_a;
    logic [7:0]  addr_a;
    logic [31:0] din_a, dat_a;
    logic        mfa_b, rw_b, wb_b, mfc_b;
    logic [7:0]  addr_b;
    logic [31:0] din_b, dat_b;
`ifdef ARM_MEM_ALIGN_CHECK_EN
    logic        mis_a, mis_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arm_mem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
        .Clk(clk), .Reset(rst), .MFA(mfa_a), .MEMADD(addr_a), .READ_WRITE(rw_a),
        .WORD_BYTE(wb_a), .DATAIN(din_a), .MEMDAT(dat_a),
`ifdef ARM_MEM_ALIGN_CHECK_EN
        .MISALIGN(mis_a),
`endif
        .MFC(mfc_a)
    );

    arm_mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
        .Clk(clk), .Reset(rst), .MFA(mfa_b), .MEMADD(addr_b), .READ_WRITE(rw_b),
        .WORD_BYTE(wb_b), .DATAIN(din_b), .MEMDAT(dat_b),
`ifdef ARM_MEM_ALIGN_CHECK_EN
        .MISALIGN(mis_b),
`endif
        .MFC(mfc_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic mfa, input logic rw, input logic wb,
                         input logic [7:0] a, input logic [31:0] d);
        if (sel) begin
            mfa_b = mfa; rw_b = rw; wb_b = wb; addr_b = a; din_b = d;
        end else begin
            mfa_a = mfa; rw_a = rw; wb_a = wb; addr_a = a; din_a = d;
        end
    endtask

    function automatic logic get_mfc(input bit sel);
        return sel ? mfc_b : mfc_a;
    endfunction

    function automatic logic [31:0] get_dat(input bit sel);
        return sel ? dat_b : dat_a;
    endfunction

    function automatic logic get_mis(input bit sel);
`ifdef ARM_MEM_ALIGN_CHECK_EN
        return sel ? mis_b : mis_a;
`else
        return sel ? 1'b0 : 1'b0;
`endif
    endfunction

    // One full handshake; inputs are scrambled right after acceptance to prove they are latched
    task automatic xact(input bit sel, input string tag, input logic rw, input logic wb,
                        input logic [7:0] a, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output int lat, output logic mis);
        int n;
        drive(sel, 1'b1, rw, wb, a, d);
        @(posedge clk); #1;
        check({tag, "_mfc_accept"}, 32'(get_mfc(sel)), 32'h0);
        drive(sel, 1'b1, ~rw, ~wb, ~a, ~d);
        n = 0;
        while (!get_mfc(sel) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        rd  = get_dat(sel);
        mis = get_mis(sel);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_mfc"}, 32'(get_mfc(sel)), 32'h1);
            check({tag, "_hold_dat"}, get_dat(sel), rd);
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(posedge clk); #1;
        check({tag, "_mfc_clear"}, 32'(get_mfc(sel)), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        mis;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mfc", 32'(mfc_a), 32'h0);
        check("rst_dat", dat_a, 32'h0);
        check("rst_mfc_w0", 32'(mfc_b), 32'h0);
        rst = 1'b0;

        // Word write then read back with 2 wait states
        xact(1'b0, "w00", 1'b0, 1'b1, 8'h00, 32'h0000CAFE, 0, rd, lat, mis);
        check("w00_lat", 32'(lat), 32'd3);
        check("w00_dat_hold", rd, 32'h0);
        xact(1'b0, "r00", 1'b1, 1'b1, 8'h00, 32'h0, 0, rd, lat, mis);
        check("r00_lat", 32'(lat), 32'd3);
        check("r00_dat", rd, 32'h0000CAFE);

        // Byte lane merge
        xact(1'b0, "w04", 1'b0, 1'b1, 8'h04, 32'hCAFE0000, 0, rd, lat, mis);
        check("w04_dat_hold", rd, 32'h0000CAFE);
        xact(1'b0, "wb06", 1'b0, 1'b0, 8'h06, 32'hFFFFFF5A, 0, rd, lat, mis);
        xact(1'b0, "r04", 1'b1, 1'b1, 8'h04, 32'h0, 0, rd, lat, mis);
        check("r04_dat", rd, 32'hCA5A0000);
        xact(1'b0, "rb07", 1'b1, 1'b0, 8'h07, 32'h0, 0, rd, lat, mis);
        check("rb07_dat", rd, 32'h000000CA);

        // MFA held after completion: outputs stable, no second transaction
        xact(1'b0, "hold", 1'b1, 1'b1, 8'h04, 32'h0, 5, rd, lat, mis);
        check("hold_dat", rd, 32'hCA5A0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_idle_mfc", 32'(mfc_a), 32'h0);
        end

        // Abort by dropping MFA in BUSY
        xact(1'b0, "w08", 1'b0, 1'b1, 8'h08, 32'h12345678, 0, rd, lat, mis);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 32'hFFFFFFFF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_mfc", 32'(mfc_a), 32'h0);
        end
        xact(1'b0, "r08a", 1'b1, 1'b1, 8'h08, 32'h0, 0, rd, lat, mis);
        check("r08a_dat", rd, 32'h12345678);

        // Abort by reset on the counter-zero edge
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h08, 32'hFFFFFFFF);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rstab_pre_mfc", 32'(mfc_a), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstab_mfc", 32'(mfc_a), 32'h0);
        check("rstab_dat", dat_a, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(posedge clk); #1;
        check("rstab_idle_mfc", 32'(mfc_a), 32'h0);
        xact(1'b0, "r08r", 1'b1, 1'b1, 8'h08, 32'h0, 0, rd, lat, mis);
        check("r08r_dat", rd, 32'h12345678);
        xact(1'b0, "r00r", 1'b1, 1'b1, 8'h00, 32'h0, 0, rd, lat, mis);
        check("r00r_dat", rd, 32'h0000CAFE);

        // Zero wait states
        xact(1'b1, "z_w00", 1'b0, 1'b1, 8'h00, 32'h0BADF00D, 0, rd, lat, mis);
        check("z_w00_lat", 32'(lat), 32'd1);
        xact(1'b1, "z_w10", 1'b0, 1'b1, 8'h10, 32'h11223344, 0, rd, lat, mis);
        xact(1'b1, "z_rb11", 1'b1, 1'b0, 8'h11, 32'h0, 0, rd, lat, mis);
        check("z_rb11_lat", 32'(lat), 32'd1);
        check("z_rb11_dat", rd, 32'h00000033);
`ifdef ARM_MEM_ALIGN_CHECK_EN
        xact(1'b1, "z_mis", 1'b0, 1'b1, 8'h01, 32'hDEADBEEF, 0, rd, lat, mis);
        check("z_mis_flag", 32'(mis), 32'h1);
        check("z_mis_dat", rd, 32'h0);
        check("z_mis_clear", 32'(mis_b), 32'h0);
        xact(1'b1, "z_r00", 1'b1, 1'b1, 8'h00, 32'h0, 0, rd, lat, mis);
        check("z_r00_dat", rd, 32'h0BADF00D);
        check("z_r00_flag", 32'(mis), 32'h0);
`else
        xact(1'b1, "z_r12", 1'b1, 1'b1, 8'h12, 32'h0, 0, rd, lat, mis);
        check("z_r12_dat", rd, 32'h11223344);
        xact(1'b1, "z_r00", 1'b1, 1'b1, 8'h00, 32'h0, 0, rd, lat, mis);
        check("z_r00_dat", rd, 32'h0BADF00D);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
